// File: rtl/strobe_gen.sv
// Programmable enable-strobe generator: 1-cycle strobes every PERIOD clocks,
// either continuously or for a fixed burst, configured through a valid/ready port.
module strobe_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DATA_WIDTH-1:0]  cfg_period,
    input  logic [BURST_WIDTH-1:0] cfg_burst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   strobe,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] remaining
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [DATA_WIDTH-1:0]  DIV_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  DIV_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [BURST_WIDTH-1:0] REM_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] REM_ZERO = {BURST_WIDTH{1'b0}};

    logic [0:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  period_q, period_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [DATA_WIDTH-1:0]  divider_q, divider_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   xfer_s;
    logic [DATA_WIDTH-1:0]  period_in_s;
    logic [DATA_WIDTH-1:0]  p_sel_s;
    logic [BURST_WIDTH-1:0] b_sel_s;

    // Config handshake; an accepted word bypasses straight into a same-cycle start.
    always_comb begin
        cfg_ready   = (state_q == IDLE);
        xfer_s      = cfg_valid && cfg_ready;
        period_in_s = (cfg_period == DIV_ZERO) ? DIV_ONE : cfg_period;
        p_sel_s     = xfer_s ? period_in_s : period_q;
        b_sel_s     = xfer_s ? cfg_burst : burst_q;
        period_d    = p_sel_s;
        burst_d     = b_sel_s;
    end

    // Run control, divider and burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        divider_d   = divider_q;
        remaining_d = remaining_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = RUN;
                    divider_d   = p_sel_s - DIV_ONE;
                    remaining_d = b_sel_s;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // stop takes priority over a strobe that is due this cycle
                if (stop) begin
                    state_d = IDLE;
                end else if (divider_q == DIV_ZERO) begin
                    strobe_d  = 1'b1;
                    divider_d = period_q - DIV_ONE;
                    if (burst_q != REM_ZERO) begin
                        remaining_d = remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        remaining_d = remaining_q;
                    end
                end else begin
                    divider_d = divider_q - DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            period_q    <= DIV_ONE;
            burst_q     <= REM_ZERO;
            divider_q   <= DIV_ZERO;
            remaining_q <= REM_ZERO;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            burst_q     <= burst_d;
            divider_q   <= divider_d;
            remaining_q <= remaining_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign strobe    = strobe_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign remaining = remaining_q;

endmodule
